// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq -- chunk-serial adder/subtractor.
//
// Computes x+y (sub=0) or x-y (sub=1) CHUNK bits per cycle. An accepted start
// latches the operands; N = WIDTH/CHUNK RUN cycles later the completed result
// is published together with carry, signed overflow and zero flags, and done
// pulses for one cycle. Results hold until the next completed operation.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request a new operation (honoured only when idle)
//   sub    in   1      0 = x+y, 1 = x-y; sampled with start
//   x      in   WIDTH  operand A
//   y      in   WIDTH  operand B
//   busy   out  1      operation in progress (RUN or DONE)
//   done   out  1      one-cycle pulse, results valid
//   s      out  WIDTH  result
//   cout   out  1      carry out of the MSB (sub: 1 = no borrow)
//   ovf    out  1      signed two's-complement overflow
//   zero   out  1      result is all zeros
// -----------------------------------------------------------------------------
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   x_q;       // operand A, shifted right one chunk per RUN cycle
  logic [WIDTH-1:0]   y_q;       // operand B, shifted likewise
  logic [WIDTH-1:0]   res_q;     // partial result, filled from the top down
  logic               sub_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   s_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;

  // Datapath for the chunk currently at the bottom of the operand shifters.
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     sum_chunk;
  logic [WIDTH-1:0]   res_d;
  logic               msb_cin;
  logic               last_chunk;

  always_comb begin
    a_chunk    = x_q[CHUNK-1:0];
    b_chunk    = y_q[CHUNK-1:0] ^ {CHUNK{sub_q}};
    sum_chunk  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Newest chunk enters at the top; after N shifts chunk 0 sits at bit 0.
    res_d      = (res_q >> CHUNK) | (WIDTH'(sum_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Carry into the chunk MSB recovered from the full-adder identity
    // s = a ^ b ^ cin; on the last chunk this is the carry into bit WIDTH-1.
    msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];
    last_chunk = (cnt_q == CNT_W'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            sub_q   <= sub;
            carry_q <= sub;     // +1 of the two's-complement negation
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q     <= x_q >> CHUNK;
          y_q     <= y_q >> CHUNK;
          res_q   <= res_d;
          carry_q <= sum_chunk[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (last_chunk) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            s_q     <= res_d;
            cout_q  <= sum_chunk[CHUNK];
            ovf_q   <= msb_cin ^ sum_chunk[CHUNK];
            zero_q  <= (res_d == '0);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits processed per RUN cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be in the range 1..WIDTH.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port start  input  1  request a new operation.
REQ-007 The block SHALL have port sub  input  1  mode: 0 = x+y, 1 = x-y; sampled with start.
REQ-008 The block SHALL have port x  input  WIDTH  operand A (two's complement or unsigned).
REQ-009 The block SHALL have port y  input  WIDTH  operand B.
REQ-010 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 The block SHALL have port done  output  1  single-cycle pulse; results valid.
REQ-012 The block SHALL have port s  output  WIDTH  result.
REQ-013 The block SHALL have port cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-014 The block SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-015 The block SHALL have port zero  output  1  result equals 0.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, with N = WIDTH/CHUNK.
REQ-017 In IDLE, start=1 at an edge SHALL latch x, y and sub, set the chunk counter to 0, load carry = sub, and move to RUN; start=0 SHALL keep the FSM in IDLE.
REQ-018 In each RUN cycle, chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) SHALL be computed as x_k + (y_k XOR {CHUNK{sub}}) + carry; the sum chunk SHALL be stored internally, the carry register SHALL be updated, and k SHALL be incremented.
REQ-019 After exactly N RUN cycles the FSM SHALL enter DONE; on that same edge s, cout, ovf and zero SHALL be loaded from the completed internal result.
REQ-020 cout SHALL equal the carry out of bit WIDTH-1.
REQ-021 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-022 zero SHALL equal 1 if and only if all WIDTH result bits are 0.
REQ-023 DONE SHALL last exactly one cycle, with done=1; the FSM SHALL then return to IDLE unconditionally.
REQ-024 Latency: done SHALL be high in the cycle beginning N edges after the edge at which start was accepted.
REQ-025 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-026 start SHALL be ignored in RUN and DONE; it SHALL be neither queued nor able to alter latched operands.
REQ-027 If start is held high continuously, operations SHALL be accepted every N+2 cycles.
REQ-028 x, y and sub SHALL be ignored whenever no start is accepted; changing them mid-operation SHALL NOT affect the result.
REQ-029 s, cout, ovf and zero SHALL change only on entry to DONE, or on reset; they SHALL hold their last values through IDLE and through the next RUN.
REQ-030 There SHALL be no partial-result visibility: s SHALL NOT expose intermediate chunks.
REQ-031 With CHUNK = WIDTH, the block SHALL complete in 1 RUN cycle (N = 1), and all rules above SHALL still hold.

Reset
REQ-032 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, zero=0, clear the chunk counter, carry and internal result, and take priority over start.
REQ-033 Reset asserted in RUN or DONE SHALL abort the operation: no done pulse SHALL follow, and outputs SHALL read reset values on the next cycle.
REQ-034 start accepted on the first edge with rst=0 after reset SHALL operate normally.

Verification (WIDTH=16, CHUNK=4, N=4 unless stated)
REQ-035 Add: start, sub=0, x=0x1234, y=0x0FCD -> done 4 cycles later; s=0x2201, cout=0, ovf=0, zero=0.
REQ-036 Subtract with borrow: sub=1, x=0x0005, y=0x0007 -> s=0xFFFE, cout=0, ovf=0; then sub=1, x=0xABCD, y=0xABCD -> s=0x0000, cout=1, zero=1.
REQ-037 Overflow: add 0x7FFF+0x0001 -> s=0x8000, ovf=1, cout=0; subtract 0x8000-0x0001 -> s=0x7FFF, ovf=1, cout=1.
REQ-038 Busy handling: start held high for 20 cycles with operands changing every cycle -> done pulses every 6 cycles; each result matches the operands sampled at acceptance; s is stable between pulses.
REQ-039 Abort: rst=1 on the second RUN cycle -> the next cycle shows busy=0 and s=0; no done pulse within the next 10 cycles.
REQ-040 Parameter sweep: WIDTH=8, CHUNK=1, add 0xFF+0x01 -> done 8 cycles after start; s=0x00, cout=1, zero=1, ovf=0; repeat with CHUNK=8 -> done after 1 cycle, same results.
